// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register.
// Carries a datapath bundle and a control bundle through DEPTH cascaded
// slots with a valid bit per slot. Stall holds every slot. Flush turns
// every slot into a bubble. A slot that is not valid always carries
// all-zero control bits, so a bubble can never write the register file or
// memory. All outputs come straight from flops.
// DEPTH must lie in 1..4 and 2**CNT_W must exceed DEPTH.
module pipe_stage_reg #(
    parameter int DATA_W     = 69,
    parameter int CTRL_W     = 3,
    parameter int DEPTH      = 1,
    parameter bit CLEAR_DATA = 1'b0,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  occupancy
);

    // Slot 0 is the entry slot. Slot DEPTH-1 drives the outputs.
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [CNT_W-1:0]  occ_q;
    logic [CNT_W-1:0]  occ_d;

    // Control and data values that enter slot 0 on a normal advance.
    // Control is zeroed for a bubble. Data is also zeroed when CLEAR_DATA is set.
    logic [CTRL_W-1:0] entry_ctrl;
    logic [DATA_W-1:0] entry_data;

    // Occupancy deltas, widened to the counter width.
    logic [CNT_W-1:0]  enter_cnt;
    logic [CNT_W-1:0]  leave_cnt;

    // Entry-slot contents, before the priority between hold and advance is applied.
    always_comb begin
        entry_ctrl = in_valid ? in_ctrl : '0;
        entry_data = in_data;
        if (CLEAR_DATA && !in_valid) begin
            entry_data = '0;
        end
        enter_cnt = CNT_W'(in_valid);
        leave_cnt = CNT_W'(valid_q[DEPTH-1]);
    end

    // Next-state of every slot and of the counter. Flush wins over stall,
    // and stall wins over a normal advance. Reset is handled in the register.
    always_comb begin
        valid_d = valid_q;
        occ_d   = occ_q;
        for (int k = 0; k < DEPTH; k++) begin
            ctrl_d[k] = ctrl_q[k];
            data_d[k] = data_q[k];
        end

        if (flush) begin
            valid_d = '0;
            occ_d   = '0;
            for (int k = 0; k < DEPTH; k++) begin
                ctrl_d[k] = '0;
                if (CLEAR_DATA) begin
                    data_d[k] = '0;
                end
            end
        end else if (!stall) begin
            valid_d[0] = in_valid;
            ctrl_d[0]  = entry_ctrl;
            data_d[0]  = entry_data;
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                ctrl_d[k]  = ctrl_q[k-1];
                data_d[k]  = data_q[k-1];
            end
            occ_d = occ_q + enter_cnt - leave_cnt;
        end
    end

    // Slot and counter registers. A synchronous reset clears every field.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ctrl_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int k = 0; k < DEPTH; k++) begin
                ctrl_q[k] <= ctrl_d[k];
                data_q[k] <= data_d[k];
            end
        end
    end

    // The last slot feeds the outputs directly. Its ctrl is already zero when
    // the slot is invalid, so no output gating is needed.
    assign out_valid = valid_q[DEPTH-1];
    assign out_ctrl  = ctrl_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the MIPS pipeline, the general form of the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a datapath bundle and a control bundle through DEPTH register slots and tracks a valid bit per slot. It adds stall (hold) and flush (bubble insertion) for hazard handling. Control bits of any invalid slot are forced to zero, so a bubble can never write the register file or memory.

Parameters:
DATA_W, 69, datapath bundle width (e.g. ALUResult 32 + WriteData 32 + writereg 5)
CTRL_W, 3, control bundle width (e.g. RegWrite, MemtoReg, MemWrite)
DEPTH, 1, number of cascaded register slots; legal range 1..4
CLEAR_DATA, 0, 1 = datapath field of a bubbled/flushed slot is zeroed; 0 = datapath field holds its last value
CNT_W, 3, occupancy counter width; must satisfy 2^CNT_W > DEPTH

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall  in  1  hold all slots unchanged this cycle
flush  in  1  invalidate all slots this cycle
in_valid  in  1  upstream stage holds a real instruction
in_data  in  DATA_W  datapath bundle from upstream stage
in_ctrl  in  CTRL_W  control bundle from upstream stage
out_valid  out  1  valid bit of last slot
out_data  out  DATA_W  datapath field of last slot
out_ctrl  out  CTRL_W  control field of last slot; always 0 when out_valid=0
occupancy  out  CNT_W  number of valid slots, 0..DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: on a clk edge with rst=1, every slot gets valid=0, ctrl=0 and data=0, regardless of stall, flush or CLEAR_DATA. After reset, out_valid=0, out_data=0, out_ctrl=0 and occupancy=0.
- Priority on each edge: rst > flush > stall > normal advance.
- Normal advance (stall=0, flush=0):
  - slot0 <= {in_valid, in_valid ? in_ctrl : 0, in_data}.
  - slot[k] <= slot[k-1] for k = 1..DEPTH-1.
  - When in_valid=0 and CLEAR_DATA=1, the data captured into slot0 is 0.
- Latency: an input sampled at edge N appears on the outputs after edge N+DEPTH-1, i.e. DEPTH edges from the cycle it is presented. With DEPTH=1 the block is timing-identical to a plain stage register.
- Stall (stall=1, flush=0): every slot holds. The input is not captured and the upstream stage is responsible for holding it. No valid bit changes, and occupancy is constant.
- Flush (flush=1): every slot gets valid=0 and ctrl=0. Data is zeroed if CLEAR_DATA=1, otherwise it holds.
  - The input on a flush cycle is discarded, even if in_valid=1.
  - flush together with stall behaves as flush alone.
- Invariant: for every slot, valid=0 implies ctrl=0. out_ctrl is driven directly from the last slot, with no output gating logic.
- occupancy is a registered count equal to the number of set valid bits. It is updated on the same edge as the slots:
  - +1 when a valid input enters and no valid slot leaves the last position;
  - -1 when a valid slot leaves and an invalid one enters;
  - otherwise unchanged.
  - Goes to 0 on flush or reset, and never exceeds DEPTH.
- Outputs are pure registers, with no combinational path from any input to any output.
- Reset, stall or flush asserted mid-stream takes effect on that same edge; no partial shift ever occurs.

Test Plan:
1. DEPTH=1, rst held 2 cycles, then in_valid=1, in_data=0x0000_0010_0000_0020_05, in_ctrl=3'b101 -> one edge later out_valid=1, out_data matches, out_ctrl=3'b101, occupancy=1; all outputs were 0 during reset.
2. DEPTH=3, stream 5 valid words D0..D4 on consecutive cycles -> D0 appears 3 edges after it is presented, one word per cycle thereafter; occupancy climbs 1,2,3, stays 3, then drains 2,1,0 after in_valid drops.
3. DEPTH=3, stream D0..D2, assert stall for 2 cycles while in_data changes to 0xDEAD -> outputs and occupancy frozen for 2 cycles; 0xDEAD is never captured; the sequence resumes D0,D1,D2 with no loss or duplication.
4. DEPTH=2, CLEAR_DATA=0, slots hold valid ctrl=3'b111, flush=1 with stall=1 and in_valid=1 -> next edge: out_valid=0, out_ctrl=0, occupancy=0, out_data unchanged; in_data is dropped.
5. DEPTH=2, CLEAR_DATA=1, in_valid=0 with in_ctrl=3'b111, in_data=0xFF..FF -> bubble emerges with out_valid=0, out_ctrl=0, out_data=0.
6. DEPTH=4, full pipe plus stall=1 plus rst=1 on the same edge -> all outputs 0 and occupancy=0 next cycle; the first valid input after release emerges after exactly 4 edges.
